// File: rtl/regfile_pkg.sv
// Shared defaults and fixed register/port indices for the multi-port register file.
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = $clog2(DEPTH_DEF);
  localparam int NR_DEF    = 2;
  localparam int NW_DEF    = 2;

  localparam int ZERO_REG  = 0;
  localparam int WB_PORT   = 0;
  localparam int LINK_PORT = 1;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between the decode/writeback stages and the register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = NR_DEF,
  parameter int NW = NW_DEF
);

  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             stall;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, stall
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, stall
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write bit per register: set on issue, cleared on writeback, set wins a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int NR    = NR_DEF,
  parameter int NW    = NW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iss_en_i,
  input  logic [AW-1:0]    iss_addr_i,
  input  logic [NW-1:0]    wr_en_i,
  input  logic [NW*AW-1:0] wr_addr_i,
  input  logic [NR*AW-1:0] rd_addr_i,
  output logic [NR-1:0]    busy_o
);

  logic [DEPTH-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (wr_en_i[j]) busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
    end
    // applied after the clears so a newer issue keeps ownership
    if (iss_en_i && iss_addr_i != AW'(ZERO_REG)) busy_d[iss_addr_i] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NR; i++) begin
      busy_o[i] = busy_q[rd_addr_i[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hazard scoreboard; define REGFILE_BYPASS_EN for
// same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int NR    = NR_DEF,
  parameter int NW    = NW_DEF
) (
  input  logic        clock,
  input  logic        reset,
  regfile_mp_if.slave bus
);

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [AW-1:0]    rd_a   [NR];
  logic [NR-1:0]    sb_busy;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             stall;

  regfile_scoreboard #(
    .DEPTH(DEPTH), .AW(AW), .NR(NR), .NW(NW)
  ) u_sb (
    .clock      (clock),
    .reset      (reset),
    .iss_en_i   (bus.iss_en),
    .iss_addr_i (bus.iss_addr),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .rd_addr_i  (bus.rd_addr),
    .busy_o     (sb_busy)
  );

  // ascending port order: the link port overrides WB on an address collision
  always_comb begin
    regs_d = regs_q;
    for (int j = WB_PORT; j < NW; j++) begin
      if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != AW'(ZERO_REG))
        regs_d[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*DW +: DW];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  always_comb begin
    for (int i = 0; i < NR; i++) rd_a[i] = bus.rd_addr[i*AW +: AW];
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NR; i++) begin
      rd_data[i*DW +: DW] = (rd_a[i] == AW'(ZERO_REG)) ? '0 : regs_q[rd_a[i]];
      rd_busy[i]          = sb_busy[i];
`ifdef REGFILE_BYPASS_EN
      for (int j = WB_PORT; j < NW; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == rd_a[i] && rd_a[i] != AW'(ZERO_REG)) begin
          rd_data[i*DW +: DW] = bus.wr_data[j*DW +: DW];
          rd_busy[i]          = 1'b0;
        end
      end
`endif
    end
  end

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (rd_busy[i] && rd_a[i] != AW'(ZERO_REG)) stall = 1'b1;
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;
  assign bus.stall   = stall;

endmodule
